// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake to instruction memory and
// feeds IF/ID through a one-entry buffer. Define FETCH_BYPASS_EN to forward zero-wait fetches.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        PC_Write_i,
    input  logic        dstall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] PC_o,
    output logic [31:0] instr_o,
    output logic        IF_ID_Write_o,
    output logic        IF_Flush_o,
    output logic        stall_o
);
    typedef enum logic {REQ, FULL} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pend_target, pend_target_nxt;
    logic [31:0] buf_pc4, buf_pc4_nxt;
    logic [31:0] buf_instr, buf_instr_nxt;
    logic        buf_valid, buf_valid_nxt;
    logic        discard, discard_nxt;
    logic        adv, redirect, fetch_ok, bypass_hit;
    logic [31:0] pc_plus4;

    assign adv      = PC_Write_i & ~dstall_i;
    assign redirect = branch_i & ~dstall_i;
    assign pc_plus4 = pc + 32'd4;
    assign fetch_ok = (state == REQ) & imem_ack_i & ~discard & ~redirect;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = fetch_ok & adv;
    assign PC_o       = bypass_hit ? pc_plus4 : buf_pc4;
    assign instr_o    = bypass_hit ? imem_data_i : buf_instr;
`else
    assign bypass_hit = 1'b0;
    assign PC_o       = buf_pc4;
    assign instr_o    = buf_instr;
`endif

    assign IF_ID_Write_o = (buf_valid & adv & ~redirect) | bypass_hit;
    assign IF_Flush_o    = redirect | (~buf_valid & adv & ~bypass_hit);
    assign stall_o       = ~IF_ID_Write_o & ~IF_Flush_o;
    assign imem_req_o    = (state == REQ);
    assign imem_addr_o   = pc;

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        pend_target_nxt = pend_target;
        buf_pc4_nxt     = buf_pc4;
        buf_instr_nxt   = buf_instr;
        buf_valid_nxt   = buf_valid;
        discard_nxt     = discard;
        case (state)
            REQ: begin
                if (imem_ack_i) begin
                    if (discard) begin
                        // stale response: a redirect arriving now beats the saved target
                        discard_nxt = 1'b0;
                        pc_nxt      = redirect ? branch_target_i : pend_target;
                    end else if (redirect) begin
                        pc_nxt = branch_target_i;
                    end else if (bypass_hit) begin
                        pc_nxt = pc_plus4;
                    end else begin
                        buf_instr_nxt = imem_data_i;
                        buf_pc4_nxt   = pc_plus4;
                        buf_valid_nxt = 1'b1;
                        pc_nxt        = pc_plus4;
                        state_nxt     = FULL;
                    end
                end else if (redirect) begin
                    // address must hold until the outstanding ack, so park the target
                    discard_nxt     = 1'b1;
                    pend_target_nxt = branch_target_i;
                end
            end
            FULL: begin
                if (redirect) begin
                    buf_valid_nxt = 1'b0;
                    pc_nxt        = branch_target_i;
                    state_nxt     = REQ;
                end else if (IF_ID_Write_o) begin
                    buf_valid_nxt = 1'b0;
                    state_nxt     = REQ;
                end
            end
            default: state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= REQ;
            pc        <= RESET_PC;
            buf_valid <= 1'b0;
            discard   <= 1'b0;
            buf_pc4   <= 32'h0;
            buf_instr <= 32'h0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            buf_valid <= buf_valid_nxt;
            discard   <= discard_nxt;
            buf_pc4   <= buf_pc4_nxt;
            buf_instr <= buf_instr_nxt;
        end
    end

    // only meaningful while discard is set, so it needs no reset
    always_ff @(posedge clk_i) begin
        pend_target <= pend_target_nxt;
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: random-latency memory plus a transaction-level reference model.
module tb_if_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
`ifdef FETCH_BYPASS_EN
    localparam int EXP_ZERO_WAIT = 8;
`else
    localparam int EXP_ZERO_WAIT = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pw = 1'b1;
    logic        ds = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic        ack = 1'b0;
    logic [31:0] mdata = 32'h0;
    logic        imem_req_o, IF_ID_Write_o, IF_Flush_o, stall_o;
    logic [31:0] imem_addr_o, PC_o, instr_o;

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk_i(clk), .rst_i(rst), .PC_Write_i(pw), .dstall_i(ds), .branch_i(br),
        .branch_target_i(tgt), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(ack), .imem_data_i(mdata), .PC_o(PC_o), .instr_o(instr_o),
        .IF_ID_Write_o(IF_ID_Write_o), .IF_Flush_o(IF_Flush_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory model
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_left = 0;
    int          mem_wait_fixed = -1;

    // reference model: next fetch address, held instruction (0 or 1 entries), stale fetch
    logic [31:0] m_pc;
    logic [63:0] m_held[$];
    bit          m_stale;
    logic [31:0] m_stale_tgt;
    logic [31:0] m_out_pc4, m_out_instr;

    logic        obs_write, obs_flush, obs_stall;
    logic [31:0] obs_pc, obs_instr;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc        = RESET_PC;
        m_held.delete();
        m_stale     = 1'b0;
        m_stale_tgt = 32'h0;
        m_out_pc4   = 32'h0;
        m_out_instr = 32'h0;
    endtask

    task automatic mem_drive();
        ack   = 1'b0;
        mdata = $urandom;
        if (imem_req_o) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_addr = imem_addr_o;
                mem_left = (mem_wait_fixed >= 0) ? mem_wait_fixed : int'($urandom_range(0, 3));
            end else begin
                chk("addr_stable", imem_addr_o, mem_addr);
            end
            if (mem_left == 0) begin
                ack      = 1'b1;
                mdata    = memfn(mem_addr);
                mem_busy = 1'b0;
            end else begin
                mem_left--;
            end
        end
    endtask

    task automatic model_step();
        bit          held, adv_m, redir_m, hit, e_write, e_flush, e_stall;
        logic [31:0] e_pc4, e_instr;
        held    = (m_held.size() != 0);
        adv_m   = pw && !ds;
        redir_m = br && !ds;
        hit     = 1'b0;
`ifdef FETCH_BYPASS_EN
        hit = !held && ack && !m_stale && !redir_m && adv_m;
`endif
        e_write = (held && adv_m && !redir_m) || hit;
        e_flush = redir_m || (!held && adv_m && !hit);
        e_stall = !e_write && !e_flush;
        if (hit) begin
            e_pc4   = m_pc + 32'd4;
            e_instr = memfn(m_pc);
        end else if (held) begin
            e_pc4   = m_held[0][63:32];
            e_instr = m_held[0][31:0];
        end else begin
            e_pc4   = m_out_pc4;
            e_instr = m_out_instr;
        end
        obs_write = IF_ID_Write_o;
        obs_flush = IF_Flush_o;
        obs_stall = stall_o;
        obs_pc    = PC_o;
        obs_instr = instr_o;
        chk("imem_req", imem_req_o, !held);
        chk("imem_addr", imem_addr_o, m_pc);
        chk("if_id_write", obs_write, e_write);
        chk("if_flush", obs_flush, e_flush);
        chk("stall", obs_stall, e_stall);
        chk("pc_out", obs_pc, e_pc4);
        chk("instr_out", obs_instr, e_instr);
        if (!held) begin
            if (ack) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                    m_pc    = redir_m ? tgt : m_stale_tgt;
                end else if (redir_m) begin
                    m_pc = tgt;
                end else if (hit) begin
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_out_pc4   = m_pc + 32'd4;
                    m_out_instr = memfn(m_pc);
                    m_held.push_back({m_out_pc4, m_out_instr});
                    m_pc = m_pc + 32'd4;
                end
            end else if (redir_m) begin
                m_stale     = 1'b1;
                m_stale_tgt = tgt;
            end
        end else if (redir_m) begin
            m_held.delete();
            m_pc = tgt;
        end else if (adv_m) begin
            m_held.delete();
        end
    endtask

    // called at posedge+1; returns at the following posedge+1
    task automatic step();
        mem_drive();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic seek_new_request();
        for (int n = 0; n < 12 && !(imem_req_o && !mem_busy); n++) step();
    endtask

    task automatic seek_full();
        for (int n = 0; n < 12 && imem_req_o; n++) step();
    endtask

    task automatic expect_delivery(input string tag, input logic [31:0] exp_pc4);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 24 && !found; n++) begin
            step();
            if (obs_write) found = 1'b1;
        end
        chk({tag, "_seen"}, found, 1'b1);
        if (found) begin
            chk({tag, "_pc"}, obs_pc, exp_pc4);
            chk({tag, "_instr"}, obs_instr, memfn(exp_pc4 - 32'd4));
        end
    endtask

    initial begin
        int          nw;
        logic [31:0] wr_pcs[$];
        logic [31:0] snap;

        model_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_pc_out", PC_o, 32'h0);
        chk("rst_instr_out", instr_o, 32'h0);
        chk("rst_req", imem_req_o, 1'b1);
        chk("rst_addr", imem_addr_o, RESET_PC);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // zero-wait streaming
        mem_wait_fixed = 0;
        nw = 0;
        repeat (8) begin
            step();
            if (obs_write) begin
                nw++;
                wr_pcs.push_back(obs_pc);
            end
        end
        chk("zero_wait_rate", nw, EXP_ZERO_WAIT);
        chk("stream_pc0", wr_pcs[0], 32'h104);
        chk("stream_pc1", wr_pcs[1], 32'h108);
        chk("stream_pc2", wr_pcs[2], 32'h10C);

        // three wait cycles
        mem_wait_fixed = 3;
        seek_new_request();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_flush", obs_flush, 1'b1);
            chk("wait_stall", obs_stall, 1'b0);
        end
        step();

        // load-use hold while an instruction is buffered
        mem_wait_fixed = 0;
        pw = 1'b0;
        seek_full();
        snap = instr_o;
        repeat (2) begin
            step();
            chk("hold_write", obs_write, 1'b0);
            chk("hold_stall", obs_stall, 1'b1);
            chk("hold_instr", obs_instr, snap);
        end
        pw = 1'b1;
        step();
        chk("hold_release", obs_write, 1'b1);

        // branch while a fetch is outstanding
        mem_wait_fixed = 3;
        seek_new_request();
        step();
        br = 1'b1; tgt = 32'h200;
        step();
        chk("branch_flush", obs_flush, 1'b1);
        br = 1'b0;
        expect_delivery("branch", 32'h204);

        // branch under data stall is held off
        mem_wait_fixed = 0;
        pw = 1'b0;
        seek_full();
        pw = 1'b1; ds = 1'b1; br = 1'b1; tgt = 32'h300;
        snap = imem_addr_o;
        repeat (2) begin
            step();
            chk("dstall_flush", obs_flush, 1'b0);
            chk("dstall_stall", obs_stall, 1'b1);
        end
        chk("dstall_pc", imem_addr_o, snap);
        ds = 1'b0;
        step();
        chk("post_dstall_flush", obs_flush, 1'b1);
        br = 1'b0;
        expect_delivery("dstall_branch", 32'h304);

        // PC wraps modulo 2^32
        mem_wait_fixed = 1;
        br = 1'b1; tgt = 32'hFFFF_FFFC;
        step();
        br = 1'b0;
        expect_delivery("wrap", 32'h0);

        // random traffic
        mem_wait_fixed = -1;
        repeat (400) begin
            pw = ($urandom_range(0, 3) != 0);
            ds = ($urandom_range(0, 5) == 0);
            br = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: tgt = 32'hFFFF_FFFC;
                1: tgt = 32'h200;
                2: tgt = $urandom & 32'hFFFF_FFFC;
                default: tgt = $urandom;
            endcase
            step();
        end
        pw = 1'b1; ds = 1'b0; br = 1'b0;

        // reset in the middle of a request
        mem_wait_fixed = 3;
        seek_new_request();
        step();
        rst = 1'b1;
        #1;
        chk("midrst_pc_out", PC_o, 32'h0);
        chk("midrst_instr_out", instr_o, 32'h0);
        chk("midrst_addr", imem_addr_o, RESET_PC);
        mem_busy = 1'b0;
        ack = 1'b0;
        model_reset();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after_rst_req", imem_req_o, 1'b1);
        chk("after_rst_addr", imem_addr_o, RESET_PC);
        mem_wait_fixed = 0;
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
